wb_rr_arbiter: RTL and testbench
================================

// Module: wb_rr_arbiter
// PURPOSE
//  Shares one Wishbone slave port between NM masters with round-robin fairness.
//  Adds a per-transfer timeout watchdog that ends a hung cycle with a synthesised err.
//  Sits between the CPU/DMA/debug masters and the shared memory/peripheral bus.
//  Replaces fixed-priority sharing where more than two masters exist.
// PARAMETERS
//  NM           4    number of masters, 2..8
//  TIMEOUT_CYC  255  cycles of stb with no ack/err before abort; 0 disables the watchdog
//  CNT_W        8    watchdog counter width; TIMEOUT_CYC must fit in CNT_W bits
// PORTS
//  i_clk      in   1              clock; all logic is on the rising edge
//  i_rstn     in   1              asynchronous, active-low reset
//  i_m2s_wb   in   NM*WB_M2S_W    master requests; master k occupies slice k
//  o_s2m_wb   out  NM*WB_S2M_W    responses; master k occupies slice k
//  o_m2s_wb   out  WB_M2S_W       request to the slave
//  i_s2m_wb   in   WB_S2M_W       slave response
//  o_grant    out  NM             one-hot registered grant
//  o_timeout  out  1              one-cycle pulse when the watchdog aborts a cycle
// BEHAVIOUR
//  Reset: state=IDLE, o_grant=0, last-grant pointer=NM-1, watchdog=0, o_timeout=0.
//   All of o_m2s_wb and o_s2m_wb are 0 during reset.
//  FSM states: IDLE, ACTIVE, ABORT, DRAIN.
//  IDLE: if any cyc is high, grant the first requester found searching from ptr+1 (mod NM).
//   Grant and ptr update are registered, so one cycle of arbitration latency.
//   Next state is ACTIVE. If no cyc is high, stay in IDLE.
//  ACTIVE (grant g): o_m2s_wb = slice g. o_s2m_wb slice g = i_s2m_wb. Every other slice = 0.
//   Granted cyc low -> IDLE on the next edge. The grant is held for the full cyc, including
//   multi-beat and locked cycles. Other requesters are never preempted.
//  Watchdog: counts each ACTIVE cycle with stb=1 and ack=0 and err=0.
//   Clears on ack, on err, on stb=0 and on leaving ACTIVE. Saturates at TIMEOUT_CYC.
//   count==TIMEOUT_CYC-1 while still stalled -> next state ABORT.
//  ABORT (exactly 1 cycle): o_m2s_wb=0, which drops cyc to the slave.
//   Master g sees err=1, ack=0 and dat=0. o_timeout=1. Next state DRAIN.
//  DRAIN: o_m2s_wb=0 and all responses are 0 until master g drops cyc, then IDLE.
//   A slave ack arriving in ABORT or DRAIN is discarded.
//  Simultaneous events:
//   - ack and timeout threshold in the same cycle: ack wins and the watchdog clears.
//   - granted cyc drops in the same cycle as the threshold: go to IDLE, no abort.
//  Release to a re-grant takes at least 2 cycles (ACTIVE->IDLE->ACTIVE).
//   A single requester therefore sees one idle bus cycle between its cycles.
//  Fairness: with all NM requesting continuously, grants rotate 0,1,..,NM-1,0.
//   No master waits more than NM-1 tenures.
//  Reset asserted mid-cycle: everything returns to reset values immediately (async).
//   No err is issued to the interrupted master.
//  Field access uses the package selectors `cyc, `stb, `ack, `err on each slice.
// STRUCTURE
//  package.vh holds: WB_M2S_W and WB_S2M_W widths; the `cyc/`stb/`ack/`err selectors;
//   the ST_IDLE/ST_ACTIVE/ST_ABORT/ST_DRAIN encodings, prefixed RR_ so they do not clash.
//  Sub-module wb_rr_pick is combinational. Inputs: req[NM-1:0], ptr. Outputs: one-hot gnt
//   and a valid flag; gnt is the first req bit found searching from ptr+1 with wrap.
//  The top level holds the FSM, grant/ptr registers, watchdog counter and output muxes.
// TESTING
//  Reset mid-transfer: grant=2, assert i_rstn=0 -> o_grant=0 and o_m2s_wb=0 the same
//   cycle; ptr=NM-1 afterwards.
//  Single master: m1 cyc/stb, slave ack after 3 cycles -> o_grant=0010 one cycle later;
//   m1 sees the ack; IDLE one cycle after cyc drops.
//  Round-robin: m0..m3 all hold cyc, each released after 1 ack -> grant order 0,1,2,3,0.
//   Each tenure starts 2 cycles after the previous release.
//  Wrap and skip: ptr=2, requests from m0 and m1 -> m0 granted first, then m1.
//  Timeout: TIMEOUT_CYC=4, m3 stb with the slave silent -> 4 stalled cycles, then ABORT.
//   During ABORT: slave cyc=0, m3 err=1, o_timeout=1. Bus stays in DRAIN until m3 drops cyc.
//  Race: ack on the same cycle as the threshold -> normal ack to the master;
//   no err, no o_timeout.

Source files
------------

// File: rtl/wb_rr_arbiter_pkg.sv
// rtl/wb_rr_arbiter_pkg.sv - Wishbone bundle layout and arbiter state encodings
package wb_rr_arbiter_pkg;

  localparam int WB_ADR_W = 16;
  localparam int WB_DAT_W = 32;

  // Master-to-slave bundle: {dat, adr, sel, we, stb, cyc}
  localparam int WB_CYC         = 0;
  localparam int WB_STB         = 1;
  localparam int WB_WE          = 2;
  localparam int WB_SEL_LSB     = 3;
  localparam int WB_ADR_LSB     = 7;
  localparam int WB_M2S_DAT_LSB = WB_ADR_LSB + WB_ADR_W;
  localparam int WB_M2S_W       = WB_M2S_DAT_LSB + WB_DAT_W;

  // Slave-to-master bundle: {dat, err, ack}
  localparam int WB_ACK         = 0;
  localparam int WB_ERR         = 1;
  localparam int WB_S2M_DAT_LSB = 2;
  localparam int WB_S2M_W       = WB_S2M_DAT_LSB + WB_DAT_W;

  // Synthesised abort response: err only, no ack, zero data
  localparam logic [WB_S2M_W-1:0] WB_S2M_ERR_ONLY = WB_S2M_W'(1) << WB_ERR;

  typedef enum logic [1:0] {
    RR_ST_IDLE   = 2'd0,
    RR_ST_ACTIVE = 2'd1,
    RR_ST_ABORT  = 2'd2,
    RR_ST_DRAIN  = 2'd3
  } rr_state_e;

endpackage

// File: rtl/wb_rr_arbiter_pick.sv
// rtl/wb_rr_arbiter_pick.sv - round-robin picker searching from ptr+1 with wrap
module wb_rr_pick #(
  parameter int NM    = 4,
  parameter int PTR_W = 2
) (
  input  logic [NM-1:0]    req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NM-1:0]    gnt,
  output logic             valid
);

  // First requester after the last granted index wins; at most one bit set
  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    for (int i = 1; i <= NM; i++) begin
      logic [PTR_W-1:0] idx;
      idx = PTR_W'((int'(ptr) + i) % NM);
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - round-robin Wishbone arbiter with stall watchdog
module wb_rr_arbiter
  import wb_rr_arbiter_pkg::*;
#(
  parameter int NM          = 4,
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic [NM*WB_M2S_W-1:0]   i_m2s_wb,
  output logic [NM*WB_S2M_W-1:0]   o_s2m_wb,
  output logic [WB_M2S_W-1:0]      o_m2s_wb,
  input  logic [WB_S2M_W-1:0]      i_s2m_wb,
  output logic [NM-1:0]            o_grant,
  output logic                     o_timeout
);

  localparam int PTR_W = (NM > 1) ? $clog2(NM) : 1;
  localparam bit WD_EN = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT_CYC);

  rr_state_e         state_q;
  logic [NM-1:0]     grant_q;
  logic [PTR_W-1:0]  ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              timeout_q;

  logic [NM-1:0]     req;
  logic [NM-1:0]     pick_gnt;
  logic              pick_valid;
  logic [PTR_W-1:0]  pick_idx;
  logic [WB_M2S_W-1:0] g_m2s;
  logic              g_stalled;

  // Collect every master's cyc as the arbitration request vector
  always_comb begin
    req = '0;
    for (int k = 0; k < NM; k++) begin
      req[k] = i_m2s_wb[k*WB_M2S_W + WB_CYC];
    end
  end

  wb_rr_pick #(.NM(NM), .PTR_W(PTR_W)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  // Encode the picked one-hot grant so it can become the new pointer
  always_comb begin
    pick_idx = '0;
    for (int k = 0; k < NM; k++) begin
      if (pick_gnt[k]) pick_idx = PTR_W'(k);
    end
  end

  // Select the granted master's request bundle
  always_comb begin
    g_m2s = '0;
    for (int k = 0; k < NM; k++) begin
      if (grant_q[k]) g_m2s = i_m2s_wb[k*WB_M2S_W +: WB_M2S_W];
    end
  end

  assign g_stalled = g_m2s[WB_STB] & ~i_s2m_wb[WB_ACK] & ~i_s2m_wb[WB_ERR];

  // Arbitration FSM with grant, pointer, watchdog and timeout pulse registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= RR_ST_IDLE;
      grant_q   <= '0;
      ptr_q     <= PTR_W'(NM - 1);
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        RR_ST_IDLE: begin
          cnt_q <= '0;
          if (pick_valid) begin
            grant_q <= pick_gnt;
            ptr_q   <= pick_idx;
            state_q <= RR_ST_ACTIVE;
          end
        end
        RR_ST_ACTIVE: begin
          if (!g_m2s[WB_CYC]) begin
            // Release wins over a simultaneous watchdog threshold
            state_q <= RR_ST_IDLE;
            grant_q <= '0;
            cnt_q   <= '0;
          end else if (g_stalled) begin
            if (WD_EN && cnt_q == CNT_LAST) begin
              state_q   <= RR_ST_ABORT;
              timeout_q <= 1'b1;
              cnt_q     <= '0;
            end else if (cnt_q != CNT_SAT) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end else begin
            // ack, err or stb low all restart the stall count
            cnt_q <= '0;
          end
        end
        RR_ST_ABORT: begin
          state_q <= RR_ST_DRAIN;
        end
        RR_ST_DRAIN: begin
          if (!g_m2s[WB_CYC]) begin
            state_q <= RR_ST_IDLE;
            grant_q <= '0;
          end
        end
        default: begin
          state_q <= RR_ST_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  // Route the granted bundle to the slave and its response back; abort forces err
  always_comb begin
    o_m2s_wb = '0;
    o_s2m_wb = '0;
    if (state_q == RR_ST_ACTIVE) o_m2s_wb = g_m2s;
    for (int k = 0; k < NM; k++) begin
      if (grant_q[k]) begin
        if (state_q == RR_ST_ACTIVE) begin
          o_s2m_wb[k*WB_S2M_W +: WB_S2M_W] = i_s2m_wb;
        end else if (state_q == RR_ST_ABORT) begin
          o_s2m_wb[k*WB_S2M_W +: WB_S2M_W] = WB_S2M_ERR_ONLY;
        end
      end
    end
  end

  assign o_grant   = grant_q;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb/tb_wb_rr_arbiter.sv - directed self-checking bench for wb_rr_arbiter
module tb_wb_rr_arbiter;
  import wb_rr_arbiter_pkg::*;

  localparam int NM = 4;
  localparam int MW = WB_M2S_W;
  localparam int SW = WB_S2M_W;

  logic              clk;
  logic              rstn;
  logic [NM*MW-1:0]  m2s;
  logic [NM*SW-1:0]  s2m_o;
  logic [MW-1:0]     slv_req;
  logic [SW-1:0]     slv_rsp;
  logic [NM-1:0]     grant;
  logic              tmo;

  int n_cmp;
  int n_bad;

  logic [SW-1:0]    rsp_ack;
  logic [SW-1:0]    rsp_err_only;
  logic [NM*SW-1:0] exp_rsp;

  wb_rr_arbiter #(.NM(NM), .TIMEOUT_CYC(4), .CNT_W(8)) dut (
    .i_clk     (clk),
    .i_rstn    (rstn),
    .i_m2s_wb  (m2s),
    .o_s2m_wb  (s2m_o),
    .o_m2s_wb  (slv_req),
    .i_s2m_wb  (slv_rsp),
    .o_grant   (grant),
    .o_timeout (tmo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Master k bundle: {dat, adr, sel, we, stb, cyc}
  task automatic set_req(input int k, input logic cyc, input logic stb);
    m2s[k*MW +: MW] = {32'hA5A0_0000 | 32'(k), 16'h0100 + 16'(k), 4'hF, 1'b0, stb, cyc};
  endtask

  function automatic logic [MW-1:0] slice_of(input int k);
    return m2s[k*MW +: MW];
  endfunction

  task automatic do_reset();
    m2s     = '0;
    slv_rsp = '0;
    rstn    = 1'b0;
    step();
    rstn    = 1'b1;
    step();
  endtask

  task automatic test_reset();
    m2s     = '0;
    slv_rsp = '0;
    rstn    = 1'b0;
    step();
    step();
    n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL reset_grant: got %b want 0000", grant); end
    n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL reset_timeout: got %b want 0", tmo); end
    n_cmp++; if (slv_req !== '0) begin n_bad++; $display("FAIL reset_m2s: got %h want 0", slv_req); end
    n_cmp++; if (s2m_o !== '0) begin n_bad++; $display("FAIL reset_s2m: got %h want 0", s2m_o); end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_single();
    do_reset();
    set_req(1, 1'b1, 1'b1);
    #1;
    n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL single_latency: got %b want 0000", grant); end
    step();
    n_cmp++; if (grant !== 4'b0010) begin n_bad++; $display("FAIL single_grant: got %b want 0010", grant); end
    n_cmp++; if (slv_req !== slice_of(1)) begin n_bad++; $display("FAIL single_m2s: got %h want %h", slv_req, slice_of(1)); end
    step();
    step();
    slv_rsp = {32'h1234_5678, 1'b0, 1'b1};
    #1;
    exp_rsp = '0;
    exp_rsp[1*SW +: SW] = slv_rsp;
    n_cmp++; if (s2m_o !== exp_rsp) begin n_bad++; $display("FAIL single_ack: got %h want %h", s2m_o, exp_rsp); end
    step();
    set_req(1, 1'b0, 1'b0);
    slv_rsp = '0;
    #1;
    n_cmp++; if (grant !== 4'b0010) begin n_bad++; $display("FAIL single_hold: got %b want 0010", grant); end
    step();
    n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL single_idle: got %b want 0000", grant); end
    n_cmp++; if (slv_req !== '0) begin n_bad++; $display("FAIL single_idle_m2s: got %h want 0", slv_req); end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int k = 0; k < NM; k++) set_req(k, 1'b1, 1'b1);
    step();
    for (int i = 0; i < 5; i++) begin
      int g;
      g = order[i];
      n_cmp++; if (grant !== 4'(1 << g)) begin n_bad++; $display("FAIL rr_grant[%0d]: got %b want %b", i, grant, 4'(1 << g)); end
      slv_rsp = rsp_ack;
      #1;
      exp_rsp = '0;
      exp_rsp[g*SW +: SW] = rsp_ack;
      n_cmp++; if (s2m_o !== exp_rsp) begin n_bad++; $display("FAIL rr_rsp[%0d]: got %h want %h", i, s2m_o, exp_rsp); end
      step();
      slv_rsp = '0;
      set_req(g, 1'b0, 1'b0);
      step();
      set_req(g, 1'b1, 1'b1);
      #1;
      n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL rr_gap[%0d]: got %b want 0000", i, grant); end
      step();
    end
  endtask

  task automatic test_wrap_skip();
    do_reset();
    set_req(2, 1'b1, 1'b1);
    step();
    n_cmp++; if (grant !== 4'b0100) begin n_bad++; $display("FAIL wrap_first: got %b want 0100", grant); end
    slv_rsp = rsp_ack;
    step();
    slv_rsp = '0;
    set_req(2, 1'b0, 1'b0);
    set_req(0, 1'b1, 1'b1);
    set_req(1, 1'b1, 1'b1);
    #1;
    n_cmp++; if (grant !== 4'b0100) begin n_bad++; $display("FAIL wrap_no_preempt: got %b want 0100", grant); end
    step();
    step();
    n_cmp++; if (grant !== 4'b0001) begin n_bad++; $display("FAIL wrap_m0: got %b want 0001", grant); end
    slv_rsp = rsp_ack;
    step();
    slv_rsp = '0;
    set_req(0, 1'b0, 1'b0);
    step();
    step();
    n_cmp++; if (grant !== 4'b0010) begin n_bad++; $display("FAIL wrap_m1: got %b want 0010", grant); end
  endtask

  task automatic test_timeout();
    do_reset();
    set_req(3, 1'b1, 1'b1);
    step();
    for (int c = 0; c < 4; c++) begin
      n_cmp++; if (tmo !== 1'b0 || slv_req[WB_CYC] !== 1'b1) begin n_bad++; $display("FAIL to_stall[%0d]: got tmo=%b cyc=%b want tmo=0 cyc=1", c, tmo, slv_req[WB_CYC]); end
      step();
    end
    slv_rsp = rsp_ack;
    #1;
    exp_rsp = '0;
    exp_rsp[3*SW +: SW] = rsp_err_only;
    n_cmp++; if (slv_req !== '0) begin n_bad++; $display("FAIL to_abort_m2s: got %h want 0", slv_req); end
    n_cmp++; if (s2m_o !== exp_rsp) begin n_bad++; $display("FAIL to_abort_err: got %h want %h", s2m_o, exp_rsp); end
    n_cmp++; if (tmo !== 1'b1) begin n_bad++; $display("FAIL to_abort_pulse: got %b want 1", tmo); end
    step();
    n_cmp++; if (slv_req !== '0 || s2m_o !== '0 || tmo !== 1'b0) begin n_bad++; $display("FAIL to_drain: got m2s=%h s2m=%h tmo=%b want all 0", slv_req, s2m_o, tmo); end
    set_req(0, 1'b1, 1'b1);
    step();
    n_cmp++; if (slv_req !== '0 || s2m_o !== '0) begin n_bad++; $display("FAIL to_drain_hold: got m2s=%h s2m=%h want 0", slv_req, s2m_o); end
    set_req(3, 1'b0, 1'b0);
    slv_rsp = '0;
    step();
    n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL to_idle: got %b want 0000", grant); end
    step();
    n_cmp++; if (grant !== 4'b0001 || slv_req !== slice_of(0)) begin n_bad++; $display("FAIL to_next: got %b/%h want 0001/%h", grant, slv_req, slice_of(0)); end
  endtask

  task automatic test_race();
    do_reset();
    set_req(1, 1'b1, 1'b1);
    step();
    step();
    step();
    step();
    slv_rsp = {32'hCAFE_0001, 1'b0, 1'b1};
    #1;
    exp_rsp = '0;
    exp_rsp[1*SW +: SW] = slv_rsp;
    n_cmp++; if (s2m_o !== exp_rsp) begin n_bad++; $display("FAIL race_ack: got %h want %h", s2m_o, exp_rsp); end
    step();
    slv_rsp = '0;
    #1;
    n_cmp++; if (tmo !== 1'b0 || slv_req !== slice_of(1)) begin n_bad++; $display("FAIL race_no_abort: got tmo=%b m2s=%h want 0/%h", tmo, slv_req, slice_of(1)); end
    step();
    step();
    step();
    n_cmp++; if (tmo !== 1'b0 || grant !== 4'b0010) begin n_bad++; $display("FAIL race_wd_cleared: got tmo=%b grant=%b want 0/0010", tmo, grant); end
    set_req(1, 1'b0, 1'b1);
    step();
    n_cmp++; if (tmo !== 1'b0 || grant !== 4'b0000) begin n_bad++; $display("FAIL race_drop: got tmo=%b grant=%b want 0/0000", tmo, grant); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(2, 1'b1, 1'b1);
    step();
    n_cmp++; if (grant !== 4'b0100 || slv_req !== slice_of(2)) begin n_bad++; $display("FAIL rst_mid_pre: got %b/%h want 0100/%h", grant, slv_req, slice_of(2)); end
    slv_rsp = rsp_ack;
    rstn    = 1'b0;
    #1;
    n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL rst_mid_grant: got %b want 0000", grant); end
    n_cmp++; if (slv_req !== '0 || s2m_o !== '0) begin n_bad++; $display("FAIL rst_mid_bus: got m2s=%h s2m=%h want 0", slv_req, s2m_o); end
    step();
    for (int k = 0; k < NM; k++) set_req(k, 1'b1, 1'b1);
    slv_rsp = '0;
    rstn    = 1'b1;
    step();
    n_cmp++; if (grant !== 4'b0001) begin n_bad++; $display("FAIL rst_mid_ptr: got %b want 0001", grant); end
  endtask

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    rstn         = 1'b0;
    m2s          = '0;
    slv_rsp      = '0;
    rsp_ack      = {32'h0000_BEEF, 1'b0, 1'b1};
    rsp_err_only = {32'h0, 1'b1, 1'b0};
    exp_rsp      = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap_skip();
    test_timeout();
    test_race();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
